// File: rtl/axi_pkg.sv
// Shared constants and state encodings for the AXI slave memory port.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_SEND  = 2'd2
    } r_state_e;

    // An access is in range only if every byte-offset bit above the RAM is zero.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int unsigned mem_aw);
        return (addr >> (mem_aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/axi_slave_mem_port_if.sv
// AXI4 write/read channel bundle between the slave-side arbiter and the memory port.
interface axi_slave_mem_port_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    // Write address
    logic [ID_WIDTH-1:0]     SLAVE_WR_ADDR_ID;
    logic [31:0]             SLAVE_WR_ADDR;
    logic [7:0]              SLAVE_WR_ADDR_LEN;
    logic [1:0]              SLAVE_WR_ADDR_BURST;
    logic                    SLAVE_WR_ADDR_VALID;
    logic                    SLAVE_WR_ADDR_READY;
    // Write data
    logic [DATA_WIDTH-1:0]   SLAVE_WR_DATA;
    logic [DATA_WIDTH/8-1:0] SLAVE_WR_STRB;
    logic                    SLAVE_WR_DATA_LAST;
    logic                    SLAVE_WR_DATA_VALID;
    logic                    SLAVE_WR_DATA_READY;
    // Write response
    logic [ID_WIDTH-1:0]     SLAVE_WR_BACK_ID;
    logic [1:0]              SLAVE_WR_BACK_RESP;
    logic                    SLAVE_WR_BACK_VALID;
    logic                    SLAVE_WR_BACK_READY;
    // Read address
    logic [ID_WIDTH-1:0]     SLAVE_RD_ADDR_ID;
    logic [31:0]             SLAVE_RD_ADDR;
    logic [7:0]              SLAVE_RD_ADDR_LEN;
    logic [1:0]              SLAVE_RD_ADDR_BURST;
    logic                    SLAVE_RD_ADDR_VALID;
    logic                    SLAVE_RD_ADDR_READY;
    // Read data
    logic [ID_WIDTH-1:0]     SLAVE_RD_BACK_ID;
    logic [DATA_WIDTH-1:0]   SLAVE_RD_DATA;
    logic [1:0]              SLAVE_RD_DATA_RESP;
    logic                    SLAVE_RD_DATA_LAST;
    logic                    SLAVE_RD_DATA_VALID;
    logic                    SLAVE_RD_DATA_READY;

    modport slave (
        input  SLAVE_WR_ADDR_ID, SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
        input  SLAVE_WR_ADDR_VALID,
        output SLAVE_WR_ADDR_READY,
        input  SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_WR_DATA_LAST, SLAVE_WR_DATA_VALID,
        output SLAVE_WR_DATA_READY,
        output SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID,
        input  SLAVE_WR_BACK_READY,
        input  SLAVE_RD_ADDR_ID, SLAVE_RD_ADDR, SLAVE_RD_ADDR_LEN, SLAVE_RD_ADDR_BURST,
        input  SLAVE_RD_ADDR_VALID,
        output SLAVE_RD_ADDR_READY,
        output SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST,
        output SLAVE_RD_DATA_VALID,
        input  SLAVE_RD_DATA_READY
    );

    modport master (
        output SLAVE_WR_ADDR_ID, SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
        output SLAVE_WR_ADDR_VALID,
        input  SLAVE_WR_ADDR_READY,
        output SLAVE_WR_DATA, SLAVE_WR_STRB, SLAVE_WR_DATA_LAST, SLAVE_WR_DATA_VALID,
        input  SLAVE_WR_DATA_READY,
        input  SLAVE_WR_BACK_ID, SLAVE_WR_BACK_RESP, SLAVE_WR_BACK_VALID,
        output SLAVE_WR_BACK_READY,
        output SLAVE_RD_ADDR_ID, SLAVE_RD_ADDR, SLAVE_RD_ADDR_LEN, SLAVE_RD_ADDR_BURST,
        output SLAVE_RD_ADDR_VALID,
        input  SLAVE_RD_ADDR_READY,
        input  SLAVE_RD_BACK_ID, SLAVE_RD_DATA, SLAVE_RD_DATA_RESP, SLAVE_RD_DATA_LAST,
        input  SLAVE_RD_DATA_VALID,
        output SLAVE_RD_DATA_READY
    );

endinterface

// File: rtl/axi_sdp_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port (1-cycle latency).
// A same-cycle read and write to one address returns the old contents.
module axi_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Byte-lane writes and registered read; non-blocking semantics give read-before-write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_slave_mem_port.sv
// AXI4 responder backed by an internal RAM. One write burst and one read burst
// in flight at a time; write and read paths run independently.
module axi_slave_mem_port
    import axi_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_slave_mem_port_if.slave  bus
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // ---------------- write path state ----------------
    w_state_e              w_state_q,  w_state_d;
    logic                  aw_ready_q, aw_ready_d;
    logic                  w_ready_q,  w_ready_d;
    logic                  bvalid_q,   bvalid_d;
    logic [ID_WIDTH-1:0]   bid_q,      bid_d;
    logic [1:0]            bresp_q,    bresp_d;
    logic [MEM_AW-1:0]     w_addr_q,   w_addr_d;
    logic [7:0]            w_len_q,    w_len_d;
    logic                  w_fixed_q,  w_fixed_d;
    logic                  w_err_q,    w_err_d;
    // One bit wider than LEN so beats past the end are recognised; saturates.
    logic [8:0]            w_cnt_q,    w_cnt_d;

    // ---------------- read path state ----------------
    r_state_e              r_state_q,  r_state_d;
    logic                  ar_ready_q, ar_ready_d;
    logic                  rvalid_q,   rvalid_d;
    logic                  rlast_q,    rlast_d;
    logic [ID_WIDTH-1:0]   rid_q,      rid_d;
    logic [1:0]            rresp_q,    rresp_d;
    logic [MEM_AW-1:0]     r_addr_q,   r_addr_d;
    logic [7:0]            r_len_q,    r_len_d;
    logic                  r_fixed_q,  r_fixed_d;
    logic                  r_err_q,    r_err_d;
    logic [7:0]            r_cnt_q,    r_cnt_d;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  ram_we;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign aw_hs = aw_ready_q && bus.SLAVE_WR_ADDR_VALID;
    assign w_hs  = w_ready_q  && bus.SLAVE_WR_DATA_VALID;
    assign b_hs  = bvalid_q   && bus.SLAVE_WR_BACK_READY;
    assign ar_hs = ar_ready_q && bus.SLAVE_RD_ADDR_VALID;
    assign r_hs  = rvalid_q   && bus.SLAVE_RD_DATA_READY;

    // Write FSM next-state: accept AW, stream beats into RAM, then hold B until taken.
    always_comb begin
        w_state_d = w_state_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        w_cnt_d   = w_cnt_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    bid_d     = bus.SLAVE_WR_ADDR_ID;
                    w_addr_d  = bus.SLAVE_WR_ADDR[MEM_AW+1:2];
                    w_len_d   = bus.SLAVE_WR_ADDR_LEN;
                    w_fixed_d = (bus.SLAVE_WR_ADDR_BURST == BURST_FIXED);
                    w_err_d   = addr_out_of_range(bus.SLAVE_WR_ADDR, MEM_AW);
                    w_cnt_d   = 9'd0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Beats beyond LEN+1 are consumed but never reach the RAM.
                    ram_we = !w_err_q && (w_cnt_q <= {1'b0, w_len_q});
                    if (!w_fixed_q) begin
                        w_addr_d = w_addr_q + 1'b1;
                    end
                    if (w_cnt_q != 9'h1FF) begin
                        w_cnt_d = w_cnt_q + 9'd1;
                    end
                    if (bus.SLAVE_WR_DATA_LAST) begin
                        // Early or late LAST both leave the count unequal to LEN here.
                        bresp_d   = (w_err_q || (w_cnt_q != {1'b0, w_len_q}))
                                    ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DATA);
        bvalid_d   = (w_state_d == W_RESP);
    end

    // Write FSM registers; READY/VALID outputs are flops decoded from next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_fixed_q  <= 1'b0;
            w_err_q    <= 1'b0;
            w_cnt_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            bvalid_q   <= bvalid_d;
            bid_q      <= bid_d;
            bresp_q    <= bresp_d;
            w_addr_q   <= w_addr_d;
            w_len_q    <= w_len_d;
            w_fixed_q  <= w_fixed_d;
            w_err_q    <= w_err_d;
            w_cnt_q    <= w_cnt_d;
        end
    end

    // Read FSM next-state: one fetch cycle per beat, then hold the beat until taken.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_fixed_d = r_fixed_q;
        r_err_d   = r_err_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rid_d     = bus.SLAVE_RD_ADDR_ID;
                    r_addr_d  = bus.SLAVE_RD_ADDR[MEM_AW+1:2];
                    r_len_d   = bus.SLAVE_RD_ADDR_LEN;
                    r_fixed_d = (bus.SLAVE_RD_ADDR_BURST == BURST_FIXED);
                    r_err_d   = addr_out_of_range(bus.SLAVE_RD_ADDR, MEM_AW);
                    rresp_d   = addr_out_of_range(bus.SLAVE_RD_ADDR, MEM_AW)
                                ? RESP_SLVERR : RESP_OKAY;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                r_state_d = R_SEND;
            end
            R_SEND: begin
                if (r_hs) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        if (!r_fixed_q) begin
                            r_addr_d = r_addr_q + 1'b1;
                        end
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        ar_ready_d = (r_state_d == R_IDLE);
        rvalid_d   = (r_state_d == R_SEND);
        rlast_d    = (r_state_d == R_SEND) && (r_cnt_d == r_len_d);
    end

    // Read FSM registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rresp_q    <= RESP_OKAY;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_fixed_q  <= 1'b0;
            r_err_q    <= 1'b0;
            r_cnt_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
            r_addr_q   <= r_addr_d;
            r_len_q    <= r_len_d;
            r_fixed_q  <= r_fixed_d;
            r_err_q    <= r_err_d;
            r_cnt_q    <= r_cnt_d;
        end
    end

    // RAM output only changes in R_FETCH, so read data stays stable while stalled.
    assign ram_re = (r_state_q == R_FETCH);

    axi_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (w_addr_q),
        .wdata (bus.SLAVE_WR_DATA),
        .wstrb (bus.SLAVE_WR_STRB[STRB_W-1:0]),
        .re    (ram_re),
        .raddr (r_addr_q),
        .rdata (ram_rdata)
    );

    assign bus.SLAVE_WR_ADDR_READY = aw_ready_q;
    assign bus.SLAVE_WR_DATA_READY = w_ready_q;
    assign bus.SLAVE_WR_BACK_VALID = bvalid_q;
    assign bus.SLAVE_WR_BACK_ID    = bid_q;
    assign bus.SLAVE_WR_BACK_RESP  = bresp_q;
    assign bus.SLAVE_RD_ADDR_READY = ar_ready_q;
    assign bus.SLAVE_RD_DATA_VALID = rvalid_q;
    assign bus.SLAVE_RD_DATA_LAST  = rlast_q;
    assign bus.SLAVE_RD_BACK_ID    = rid_q;
    assign bus.SLAVE_RD_DATA_RESP  = rresp_q;
    // Out-of-range reads and idle cycles present zero data.
    assign bus.SLAVE_RD_DATA       = (rvalid_q && !r_err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi_slave_mem_port.sv
// Directed bench for axi_slave_mem_port: vector table of write+readback pairs,
// plus hand sequences for stalls, collisions and reset mid-burst.
module tb_axi_slave_mem_port;
    import axi_pkg::*;

    localparam int IDW = 4;
    localparam int DW  = 32;
    localparam int MAW = 10;
    localparam int TMO = 50;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_slave_mem_port_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) bus ();

    axi_slave_mem_port #(
        .ID_WIDTH   (IDW),
        .DATA_WIDTH (DW),
        .MEM_AW     (MAW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      waddr;
        logic [7:0]       wlen;
        logic [1:0]       wburst;
        logic [31:0]      d0;
        logic [3:0]       strb;
        int               nbeats;
        logic [1:0]       bresp;
        logic [31:0]      raddr;
        logic [7:0]       rlen;
        logic [1:0]       rburst;
        logic [3:0][31:0] rdata;
        logic [1:0]       rresp;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [3:0][31:0] mk4(input logic [31:0] a0, input logic [31:0] a1,
                                             input logic [31:0] a2, input logic [31:0] a3);
        logic [3:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write burst: nbeats beats carrying d0+i, LAST on the final one; B held bwait cycles.
    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                            input int nbeats, input int bwait, input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        bus.SLAVE_WR_ADDR_ID    = id;
        bus.SLAVE_WR_ADDR       = addr;
        bus.SLAVE_WR_ADDR_LEN   = len;
        bus.SLAVE_WR_ADDR_BURST = burst;
        bus.SLAVE_WR_ADDR_VALID = 1'b1;
        n = 0;
        while (bus.SLAVE_WR_ADDR_READY !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        chk("aw_ready_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1;
        bus.SLAVE_WR_ADDR_VALID = 1'b0;
        @(negedge clk);
        chk("w_ready_after_aw", 32'(bus.SLAVE_WR_DATA_READY), 32'd1);
        for (int b = 0; b < nbeats; b++) begin
            bus.SLAVE_WR_DATA       = d0 + 32'(b);
            bus.SLAVE_WR_STRB       = strb;
            bus.SLAVE_WR_DATA_LAST  = (b == nbeats - 1);
            bus.SLAVE_WR_DATA_VALID = 1'b1;
            n = 0;
            while (bus.SLAVE_WR_DATA_READY !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
            if (n >= TMO) chk("w_ready_wait", 32'd0, 32'd1);
            @(posedge clk); #1;
            bus.SLAVE_WR_DATA_VALID = 1'b0;
            bus.SLAVE_WR_DATA_LAST  = 1'b0;
            @(negedge clk);
        end
        chk("bvalid_m1", 32'(bus.SLAVE_WR_BACK_VALID), 32'd1);
        chk("bid", 32'(bus.SLAVE_WR_BACK_ID), 32'(id));
        chk("bresp", 32'(bus.SLAVE_WR_BACK_RESP), 32'(exp_resp));
        for (int c = 0; c < bwait; c++) begin
            @(negedge clk);
            chk("bvalid_held", 32'(bus.SLAVE_WR_BACK_VALID), 32'd1);
            chk("bid_held", 32'(bus.SLAVE_WR_BACK_ID), 32'(id));
        end
        bus.SLAVE_WR_BACK_READY = 1'b1;
        @(posedge clk); #1;
        bus.SLAVE_WR_BACK_READY = 1'b0;
        @(negedge clk);
        chk("bvalid_drop", 32'(bus.SLAVE_WR_BACK_VALID), 32'd0);
        $display("WR id=%h addr=%h len=%0d beats=%0d exp_bresp=%b", id, addr, len, nbeats, exp_resp);
    endtask

    // Read burst with RREADY high except for a 5-cycle stall on beat stall_beat (-1: none).
    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0][31:0] exp,
                            input logic [1:0] exp_resp, input int stall_beat);
        int n;
        @(negedge clk);
        bus.SLAVE_RD_ADDR_ID    = id;
        bus.SLAVE_RD_ADDR       = addr;
        bus.SLAVE_RD_ADDR_LEN   = len;
        bus.SLAVE_RD_ADDR_BURST = burst;
        bus.SLAVE_RD_ADDR_VALID = 1'b1;
        bus.SLAVE_RD_DATA_READY = 1'b1;
        n = 0;
        while (bus.SLAVE_RD_ADDR_READY !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
        chk("ar_ready_wait", 32'(n < TMO), 32'd1);
        @(posedge clk); #1;
        bus.SLAVE_RD_ADDR_VALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (k == stall_beat) bus.SLAVE_RD_DATA_READY = 1'b0;
            @(negedge clk);
            n = 1;
            while (bus.SLAVE_RD_DATA_VALID !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
            chk("r_beat_latency", 32'(n), 32'd2);
            if (k == stall_beat) begin
                for (int c = 0; c < 5; c++) begin
                    chk("stall_valid", 32'(bus.SLAVE_RD_DATA_VALID), 32'd1);
                    chk("stall_data", bus.SLAVE_RD_DATA, exp[k]);
                    chk("stall_last", 32'(bus.SLAVE_RD_DATA_LAST), 32'(k == int'(len)));
                    @(negedge clk);
                end
                bus.SLAVE_RD_DATA_READY = 1'b1;
            end
            chk("r_data", bus.SLAVE_RD_DATA, exp[k]);
            chk("r_last", 32'(bus.SLAVE_RD_DATA_LAST), 32'(k == int'(len)));
            chk("r_id", 32'(bus.SLAVE_RD_BACK_ID), 32'(id));
            chk("r_resp", 32'(bus.SLAVE_RD_DATA_RESP), 32'(exp_resp));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("rvalid_drop", 32'(bus.SLAVE_RD_DATA_VALID), 32'd0);
        $display("RD id=%h addr=%h len=%0d exp_rresp=%b d0=%h", id, addr, len, exp_resp, exp[0]);
    endtask

    initial begin
        logic seen_b;

        bus.SLAVE_WR_ADDR_ID = '0; bus.SLAVE_WR_ADDR = '0; bus.SLAVE_WR_ADDR_LEN = '0;
        bus.SLAVE_WR_ADDR_BURST = '0; bus.SLAVE_WR_ADDR_VALID = 1'b0;
        bus.SLAVE_WR_DATA = '0; bus.SLAVE_WR_STRB = '0; bus.SLAVE_WR_DATA_LAST = 1'b0;
        bus.SLAVE_WR_DATA_VALID = 1'b0; bus.SLAVE_WR_BACK_READY = 1'b0;
        bus.SLAVE_RD_ADDR_ID = '0; bus.SLAVE_RD_ADDR = '0; bus.SLAVE_RD_ADDR_LEN = '0;
        bus.SLAVE_RD_ADDR_BURST = '0; bus.SLAVE_RD_ADDR_VALID = 1'b0;
        bus.SLAVE_RD_DATA_READY = 1'b0;

        vecs[0]  = '{4'h5, 32'h10,   8'd3, BURST_INCR,  32'hA0,       4'hF, 4, RESP_OKAY,
                     32'h10,   8'd3, BURST_INCR,  mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3), RESP_OKAY};
        vecs[1]  = '{4'h3, 32'h40,   8'd0, BURST_INCR,  32'h12345678, 4'hF, 1, RESP_OKAY,
                     32'h40,   8'd0, BURST_INCR,  mk4(32'h12345678, 0, 0, 0), RESP_OKAY};
        vecs[2]  = '{4'h6, 32'h40,   8'd0, BURST_INCR,  32'hFFFFFFFF, 4'h3, 1, RESP_OKAY,
                     32'h40,   8'd0, BURST_INCR,  mk4(32'h1234FFFF, 0, 0, 0), RESP_OKAY};
        vecs[3]  = '{4'h1, 32'h0,    8'd0, BURST_INCR,  32'hCAFEF00D, 4'hF, 1, RESP_OKAY,
                     32'h0,    8'd0, BURST_INCR,  mk4(32'hCAFEF00D, 0, 0, 0), RESP_OKAY};
        // 0x1000 aliases word 0 if the range check were missing.
        vecs[4]  = '{4'h9, 32'h1000, 8'd1, BURST_INCR,  32'h55555555, 4'hF, 2, RESP_SLVERR,
                     32'h0,    8'd0, BURST_INCR,  mk4(32'hCAFEF00D, 0, 0, 0), RESP_OKAY};
        vecs[5]  = '{4'h2, 32'hFFC,  8'd1, BURST_INCR,  32'hB0,       4'hF, 2, RESP_OKAY,
                     32'hFFC,  8'd1, BURST_INCR,  mk4(32'hB0, 32'hB1, 0, 0), RESP_OKAY};
        vecs[6]  = '{4'h7, 32'h20,   8'd2, BURST_FIXED, 32'hC0,       4'hF, 3, RESP_OKAY,
                     32'h20,   8'd2, BURST_FIXED, mk4(32'hC2, 32'hC2, 32'hC2, 0), RESP_OKAY};
        vecs[7]  = '{4'h4, 32'h60,   8'd3, BURST_INCR,  32'hE0,       4'hF, 2, RESP_SLVERR,
                     32'h60,   8'd1, BURST_INCR,  mk4(32'hE0, 32'hE1, 0, 0), RESP_OKAY};
        vecs[8]  = '{4'h8, 32'h70,   8'd1, BURST_INCR,  32'h90,       4'hF, 2, RESP_OKAY,
                     32'h70,   8'd1, BURST_INCR,  mk4(32'h90, 32'h91, 0, 0), RESP_OKAY};
        vecs[9]  = '{4'hA, 32'h70,   8'd0, BURST_INCR,  32'hF0,       4'hF, 3, RESP_SLVERR,
                     32'h70,   8'd1, BURST_INCR,  mk4(32'hF0, 32'h91, 0, 0), RESP_OKAY};
        vecs[10] = '{4'hF, 32'h3,    8'd0, BURST_INCR,  32'hDEADBEEF, 4'hF, 1, RESP_OKAY,
                     32'h0,    8'd0, BURST_INCR,  mk4(32'hDEADBEEF, 0, 0, 0), RESP_OKAY};

        // Reset values
        #12;
        chk("rst_aw_ready", 32'(bus.SLAVE_WR_ADDR_READY), 32'd0);
        chk("rst_w_ready",  32'(bus.SLAVE_WR_DATA_READY), 32'd0);
        chk("rst_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 32'd0);
        chk("rst_bvalid",   32'(bus.SLAVE_WR_BACK_VALID), 32'd0);
        chk("rst_rvalid",   32'(bus.SLAVE_RD_DATA_VALID), 32'd0);
        chk("rst_rlast",    32'(bus.SLAVE_RD_DATA_LAST), 32'd0);
        chk("rst_bid",      32'(bus.SLAVE_WR_BACK_ID), 32'd0);
        chk("rst_rid",      32'(bus.SLAVE_RD_BACK_ID), 32'd0);
        chk("rst_bresp",    32'(bus.SLAVE_WR_BACK_RESP), 32'd0);
        chk("rst_rresp",    32'(bus.SLAVE_RD_DATA_RESP), 32'd0);
        chk("rst_rdata",    bus.SLAVE_RD_DATA, 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_aw_ready", 32'(bus.SLAVE_WR_ADDR_READY), 32'd1);
        chk("post_rst_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 32'd1);
        chk("post_rst_w_ready",  32'(bus.SLAVE_WR_DATA_READY), 32'd0);

        // Vector table
        for (int i = 0; i < 11; i++) begin
            wr_burst(vecs[i].id, vecs[i].waddr, vecs[i].wlen, vecs[i].wburst, vecs[i].d0,
                     vecs[i].strb, vecs[i].nbeats, 0, vecs[i].bresp);
            rd_burst(vecs[i].id, vecs[i].raddr, vecs[i].rlen, vecs[i].rburst, vecs[i].rdata,
                     vecs[i].rresp, -1);
        end

        // Out-of-range read: zero data with SLVERR on every beat
        rd_burst(4'hC, 32'h1000, 8'd1, BURST_INCR, mk4(0, 0, 0, 0), RESP_SLVERR, -1);

        // Read stall mid-burst
        rd_burst(4'h5, 32'h10, 8'd3, BURST_INCR, mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3), RESP_OKAY, 1);
        // Stall on the LAST beat as well
        rd_burst(4'h6, 32'h10, 8'd3, BURST_INCR, mk4(32'hA0, 32'hA1, 32'hA2, 32'hA3), RESP_OKAY, 3);

        // BACK_READY held low
        wr_burst(4'hE, 32'h80, 8'd0, BURST_INCR, 32'h13572468, 4'hF, 1, 4, RESP_OKAY);
        rd_burst(4'hE, 32'h80, 8'd0, BURST_INCR, mk4(32'h13572468, 0, 0, 0), RESP_OKAY, -1);

        // Same-edge read and write to word 0x10: read sees old data
        @(negedge clk);
        bus.SLAVE_WR_ADDR_ID = 4'hB; bus.SLAVE_WR_ADDR = 32'h10; bus.SLAVE_WR_ADDR_LEN = 8'd0;
        bus.SLAVE_WR_ADDR_BURST = BURST_INCR; bus.SLAVE_WR_ADDR_VALID = 1'b1;
        @(posedge clk); #1;
        bus.SLAVE_WR_ADDR_VALID = 1'b0;
        @(negedge clk);
        chk("coll_w_ready", 32'(bus.SLAVE_WR_DATA_READY), 32'd1);
        bus.SLAVE_RD_ADDR_ID = 4'hD; bus.SLAVE_RD_ADDR = 32'h10; bus.SLAVE_RD_ADDR_LEN = 8'd0;
        bus.SLAVE_RD_ADDR_BURST = BURST_INCR; bus.SLAVE_RD_ADDR_VALID = 1'b1;
        bus.SLAVE_RD_DATA_READY = 1'b1;
        chk("coll_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 32'd1);
        @(posedge clk); #1;
        bus.SLAVE_RD_ADDR_VALID = 1'b0;
        @(negedge clk);
        bus.SLAVE_WR_DATA = 32'h77777777; bus.SLAVE_WR_STRB = 4'hF;
        bus.SLAVE_WR_DATA_LAST = 1'b1; bus.SLAVE_WR_DATA_VALID = 1'b1;
        @(posedge clk); #1;
        bus.SLAVE_WR_DATA_VALID = 1'b0; bus.SLAVE_WR_DATA_LAST = 1'b0;
        @(negedge clk);
        chk("coll_rvalid", 32'(bus.SLAVE_RD_DATA_VALID), 32'd1);
        chk("coll_old_data", bus.SLAVE_RD_DATA, 32'hA0);
        chk("coll_rlast", 32'(bus.SLAVE_RD_DATA_LAST), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("coll_bvalid", 32'(bus.SLAVE_WR_BACK_VALID), 32'd1);
        chk("coll_bid", 32'(bus.SLAVE_WR_BACK_ID), 32'hB);
        chk("coll_bresp", 32'(bus.SLAVE_WR_BACK_RESP), 32'(RESP_OKAY));
        bus.SLAVE_WR_BACK_READY = 1'b1;
        @(posedge clk); #1;
        bus.SLAVE_WR_BACK_READY = 1'b0;
        $display("COLLIDE wr+rd addr=00000010 read_old=%h", bus.SLAVE_RD_DATA);
        rd_burst(4'hD, 32'h10, 8'd0, BURST_INCR, mk4(32'h77777777, 0, 0, 0), RESP_OKAY, -1);

        // Reset asserted while in W_DATA
        @(negedge clk);
        bus.SLAVE_WR_ADDR_ID = 4'h2; bus.SLAVE_WR_ADDR = 32'h100; bus.SLAVE_WR_ADDR_LEN = 8'd3;
        bus.SLAVE_WR_ADDR_BURST = BURST_INCR; bus.SLAVE_WR_ADDR_VALID = 1'b1;
        @(posedge clk); #1;
        bus.SLAVE_WR_ADDR_VALID = 1'b0;
        @(negedge clk);
        bus.SLAVE_WR_DATA = 32'h99; bus.SLAVE_WR_STRB = 4'hF; bus.SLAVE_WR_DATA_VALID = 1'b1;
        @(posedge clk); #1;
        bus.SLAVE_WR_DATA_VALID = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_aw_ready", 32'(bus.SLAVE_WR_ADDR_READY), 32'd0);
        chk("mid_rst_w_ready",  32'(bus.SLAVE_WR_DATA_READY), 32'd0);
        chk("mid_rst_ar_ready", 32'(bus.SLAVE_RD_ADDR_READY), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_aw_ready", 32'(bus.SLAVE_WR_ADDR_READY), 32'd1);
        chk("rel_w_ready",  32'(bus.SLAVE_WR_DATA_READY), 32'd0);
        seen_b = 1'b0;
        for (int c = 0; c < 6; c++) begin
            seen_b = seen_b | bus.SLAVE_WR_BACK_VALID;
            @(negedge clk);
        end
        chk("no_b_after_rst", 32'(seen_b), 32'd0);
        $display("RESET mid-write: aw_ready=%b bvalid_seen=%b", bus.SLAVE_WR_ADDR_READY, seen_b);

        // Port still usable after the abandoned burst
        wr_burst(4'h3, 32'h100, 8'd0, BURST_INCR, 32'h0BADF00D, 4'hF, 1, 0, RESP_OKAY);
        rd_burst(4'h3, 32'h100, 8'd0, BURST_INCR, mk4(32'h0BADF00D, 0, 0, 0), RESP_OKAY, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
